// File: rtl/seq_detect_arbiter.sv
// Round-robin front end that feeds one frame at a time into a shared serial
// overlapping pattern detector and returns a per-frame match count.
module seq_detect_arbiter #(
  parameter int                DATA_W  = 8,
  parameter int                PAT_W   = 4,
  parameter logic [PAT_W-1:0]  PATTERN = 4'b1010,
  parameter int                CNT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              resp_valid,
  output logic              resp_id,
  output logic [CNT_W-1:0]  resp_count,
  output logic              match,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int               BC_W    = $clog2(DATA_W);
  localparam logic [BC_W-1:0]  BC_LAST = BC_W'(DATA_W - 1);
  localparam logic [BC_W-1:0]  BC_ARM  = BC_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic               rr_q, rr_d;
  logic               id_q, id_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [PAT_W-2:0]   hist_q, hist_d;
  logic [BC_W-1:0]    bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_id_q, resp_id_d;
  logic [CNT_W-1:0]   resp_count_q, resp_count_d;
  logic               match_q, match_d;

  logic               grant1;
  logic               cur_bit;
  logic [PAT_W-1:0]   window;
  logic               hit;
  logic [CNT_W-1:0]   count_inc;

  always_comb begin
    if (req0_valid && req1_valid) grant1 = rr_q;
    else                          grant1 = req1_valid;
  end

  // Gated by reset so nothing can look accepted while the block is held in reset.
  assign req0_ready = reset && (state_q == IDLE) && req0_valid && !grant1;
  assign req1_ready = reset && (state_q == IDLE) && req1_valid && grant1;

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    id_d         = id_q;
    shreg_d      = shreg_q;
    hist_d       = hist_q;
    bitcnt_d     = bitcnt_q;
    count_d      = count_q;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_count_d = resp_count_q;
    match_d      = 1'b0;

    cur_bit   = shreg_q[DATA_W-1];
    window    = {hist_q, cur_bit};
    hit       = (window == PATTERN) && (bitcnt_q >= BC_ARM);
    count_inc = (hit && (count_q != CNT_MAX)) ? count_q + 1'b1 : count_q;

    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          shreg_d  = grant1 ? req1_data : req0_data;
          id_d     = grant1;
          rr_d     = ~grant1;
          hist_d   = '0;
          bitcnt_d = '0;
          count_d  = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d  = {shreg_q[DATA_W-2:0], 1'b0};
        bitcnt_d = bitcnt_q + 1'b1;
        hist_d   = window[PAT_W-2:0];
        match_d  = hit;
        count_d  = count_inc;
        // Response is loaded on the last shift edge so it is visible during REPORT.
        if (bitcnt_q == BC_LAST) begin
          state_d      = REPORT;
          resp_valid_d = 1'b1;
          resp_id_d    = id_q;
          resp_count_d = count_inc;
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d      = IDLE;
        rr_d         = 1'b0;
        id_d         = 1'b0;
        shreg_d      = '0;
        hist_d       = '0;
        bitcnt_d     = '0;
        count_d      = '0;
        resp_id_d    = 1'b0;
        resp_count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      id_q         <= 1'b0;
      shreg_q      <= '0;
      hist_q       <= '0;
      bitcnt_q     <= '0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_count_q <= '0;
      match_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      id_q         <= id_d;
      shreg_q      <= shreg_d;
      hist_q       <= hist_d;
      bitcnt_q     <= bitcnt_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_count_q <= resp_count_d;
      match_q      <= match_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_count = resp_count_q;
  assign match      = match_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Bench for seq_detect_arbiter: directed scenarios plus random traffic checked
// against a window-scanning reference model and a round-robin grant model.
module tb_seq_detect_arbiter;
  localparam int               DATA_W  = 8;
  localparam int               PAT_W   = 4;
  localparam int               CNT_W   = 4;
  localparam logic [PAT_W-1:0] PATTERN = 4'b1010;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req0_valid = 1'b0;
  logic [DATA_W-1:0] req0_data = '0;
  logic              req1_valid = 1'b0;
  logic [DATA_W-1:0] req1_data = '0;
  logic              req0_ready, req1_ready, resp_valid, resp_id, match, busy;
  logic [CNT_W-1:0]  resp_count;

  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_ready, s_ready1, s_resp_valid, s_resp_id, s_match, s_busy;
  logic [0:0]        s_resp_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rr_m  = 0;

  seq_detect_arbiter #(.DATA_W(DATA_W), .PAT_W(PAT_W), .PATTERN(PATTERN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_count(resp_count),
    .match(match), .busy(busy)
  );

  seq_detect_arbiter #(.DATA_W(DATA_W), .PAT_W(PAT_W), .PATTERN(PATTERN), .CNT_W(1)) dut_sat (
    .clk(clk), .reset(reset),
    .req0_valid(s_valid), .req0_data(s_data), .req0_ready(s_ready),
    .req1_valid(1'b0), .req1_data(8'h00), .req1_ready(s_ready1),
    .resp_valid(s_resp_valid), .resp_id(s_resp_id), .resp_count(s_resp_count),
    .match(s_match), .busy(s_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model_count(input logic [DATA_W-1:0] d, input int cmax);
    int n;
    n = 0;
    for (int i = 0; i <= DATA_W - PAT_W; i++)
      if (d[DATA_W-1-i -: PAT_W] == PATTERN) n++;
    return (n > cmax) ? cmax : n;
  endfunction

  // Bit k set when a match completes on the k-th received bit (0-based).
  function automatic logic [DATA_W-1:0] model_hits(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] h;
    h = '0;
    for (int i = 0; i <= DATA_W - PAT_W; i++)
      if (d[DATA_W-1-i -: PAT_W] == PATTERN) h[i+PAT_W-1] = 1'b1;
    return h;
  endfunction

  function automatic int model_grant(input logic v0, input logic v1, input int rr);
    if (v0 && v1) return rr;
    return v1 ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rr_m  = 0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_accept(input string tag, output int who, output int at);
    who = -1;
    at  = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (req0_valid && req0_ready)      who = 0;
      else if (req1_valid && req1_ready) who = 1;
      if (who >= 0) at = cyc;
      tick();
      if (who >= 0) break;
    end
    if (who < 0) begin
      total++;
      bad++;
      $display("FAIL %s accept: no handshake within 40 cycles", tag);
    end
  endtask

  task automatic collect(input string tag, input int exp_id, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] hits_seen, hits_exp;
    logic [CNT_W-1:0]  cnt_seen, cnt_exp;
    logic              id_seen;
    int                resp_at, n_resp;
    bit                bad_busy;
    hits_seen = '0;
    cnt_seen  = '0;
    id_seen   = 1'b0;
    resp_at   = -1;
    n_resp    = 0;
    bad_busy  = 1'b0;
    hits_exp  = model_hits(d);
    cnt_exp   = CNT_W'(model_count(d, 2**CNT_W - 1));
    for (int c = 1; c <= DATA_W + 1; c++) begin
      if (c >= 2) hits_seen[c-2] = match;
      if (!busy || req0_ready || req1_ready) bad_busy = 1'b1;
      if (resp_valid) begin
        n_resp++;
        if (resp_at < 0) begin
          resp_at  = c;
          cnt_seen = resp_count;
          id_seen  = resp_id;
        end
      end
      tick();
    end
    total++;
    if (hits_seen !== hits_exp) begin
      bad++;
      $display("FAIL %s match: got %b need %b", tag, hits_seen, hits_exp);
    end
    total++;
    if (resp_at != DATA_W + 1 || n_resp != 1) begin
      bad++;
      $display("FAIL %s resp_timing: got offset %0d pulses %0d need offset %0d pulses 1",
               tag, resp_at, n_resp, DATA_W + 1);
    end
    total++;
    if (id_seen !== exp_id[0]) begin
      bad++;
      $display("FAIL %s resp_id: got %0d need %0d", tag, id_seen, exp_id);
    end
    total++;
    if (cnt_seen !== cnt_exp) begin
      bad++;
      $display("FAIL %s resp_count: got %0d need %0d", tag, cnt_seen, cnt_exp);
    end
    total++;
    if (bad_busy) begin
      bad++;
      $display("FAIL %s busy: got busy low or ready high during frame, need busy=1 ready=0", tag);
    end
    total++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || resp_count !== cnt_exp) begin
      bad++;
      $display("FAIL %s after: got busy=%b resp_valid=%b resp_count=%0d need 0 0 %0d",
               tag, busy, resp_valid, resp_count, cnt_exp);
    end
  endtask

  task automatic serve(input string tag, output int at);
    int                who, exp_who;
    logic [DATA_W-1:0] d;
    exp_who = model_grant(req0_valid, req1_valid, rr_m);
    wait_accept(tag, who, at);
    if (who < 0) return;
    total++;
    if (who !== exp_who) begin
      bad++;
      $display("FAIL %s grant: got %0d need %0d", tag, who, exp_who);
    end
    rr_m = 1 - exp_who;
    d = (exp_who == 1) ? req1_data : req0_data;
    collect(tag, exp_who, d);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req0_valid = 1'b1;
    tick();
    tick();
    total++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || match !== 1'b0) begin
      bad++;
      $display("FAIL rst_ctrl: got busy=%b resp_valid=%b match=%b need 0 0 0", busy, resp_valid, match);
    end
    total++;
    if (resp_count !== '0 || resp_id !== 1'b0) begin
      bad++;
      $display("FAIL rst_resp: got id=%b count=%0d need 0 0", resp_id, resp_count);
    end
    total++;
    if (req0_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_ready: got %b need 0", req0_ready);
    end
    req0_valid = 1'b0;
    reset = 1'b1;
    rr_m  = 0;
  endtask

  task automatic test_single();
    int at;
    req0_valid = 1'b1;
    req0_data  = 8'b10101010;
    serve("t1", at);
    req0_valid = 1'b0;
  endtask

  task automatic test_req1_frames();
    int at;
    req1_valid = 1'b1;
    req1_data  = 8'b00001010;
    serve("t2a", at);
    req1_data  = 8'b11111111;
    serve("t2b", at);
    req1_data  = 8'b00010100;
    serve("t2c", at);
    req1_valid = 1'b0;
  endtask

  task automatic test_both_after_reset();
    int at;
    do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 8'b10100000;
    req1_data  = 8'b10100000;
    serve("t3a", at);
    req0_valid = 1'b0;
    serve("t3b", at);
    req1_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int at0, at1;
    req0_valid = 1'b1;
    req0_data  = 8'b10000000;
    serve("t4a", at0);
    req0_data  = 8'b10101010;
    serve("t4b", at1);
    req0_valid = 1'b0;
    total++;
    if (at1 - at0 != DATA_W + 2) begin
      bad++;
      $display("FAIL t4 spacing: got %0d need %0d", at1 - at0, DATA_W + 2);
    end
  endtask

  task automatic test_alternate();
    int at, prev_at;
    do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 8'($urandom);
    req1_data  = 8'($urandom);
    prev_at = -1;
    for (int k = 0; k < 4; k++) begin
      serve("t5", at);
      if (prev_at >= 0) begin
        total++;
        if (at - prev_at != DATA_W + 2) begin
          bad++;
          $display("FAIL t5 spacing: got %0d need %0d", at - prev_at, DATA_W + 2);
        end
      end
      prev_at   = at;
      req0_data = 8'($urandom);
      req1_data = 8'($urandom);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int who, at, n_resp;
    req0_valid = 1'b1;
    req1_valid = 1'b0;
    req0_data  = 8'b10101010;
    wait_accept("t6", who, at);
    rr_m = 1;
    req0_valid = 1'b0;
    tick();
    tick();
    tick();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    reset = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL t6 reset_now: got busy=%b r0=%b r1=%b need 0 0 0", busy, req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rr_m = 0;
    n_resp = 0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (resp_valid) n_resp++;
      tick();
    end
    total++;
    if (n_resp != 0) begin
      bad++;
      $display("FAIL t6 dropped: got %0d resp pulses need 0", n_resp);
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 8'b01010000;
    req1_data  = 8'b10101010;
    serve("t6_next", at);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_saturate();
    logic [DATA_W-1:0] frames [2];
    logic [0:0]        cnt;
    bit                acc, seen;
    frames[0] = 8'b10101010;
    frames[1] = 8'b10000000;
    for (int f = 0; f < 2; f++) begin
      s_valid = 1'b1;
      s_data  = frames[f];
      seen = 1'b0;
      cnt  = 1'b0;
      for (int i = 0; i < 40; i++) begin
        #1;
        acc = s_ready;
        tick();
        if (acc) break;
      end
      s_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (s_resp_valid) begin
          seen = 1'b1;
          cnt  = s_resp_count;
          break;
        end
        tick();
      end
      total++;
      if (!seen || cnt !== 1'(model_count(frames[f], 1))) begin
        bad++;
        $display("FAIL t7 sat_count: got seen=%b count=%0d need seen=1 count=%0d",
                 seen, cnt, model_count(frames[f], 1));
      end
      tick();
      total++;
      if (s_busy !== 1'b0 || s_match !== 1'b0 || s_ready1 !== 1'b0 || s_resp_id !== 1'b0) begin
        bad++;
        $display("FAIL t7 sat_idle: got busy=%b match=%b r1=%b id=%b need 0 0 0 0",
                 s_busy, s_match, s_ready1, s_resp_id);
      end
    end
  endtask

  task automatic test_random();
    int at;
    logic [1:0] v;
    for (int k = 0; k < 30; k++) begin
      v = 2'($urandom_range(1, 3));
      req0_valid = v[0];
      req1_valid = v[1];
      req0_data  = 8'($urandom);
      req1_data  = 8'($urandom);
      serve("rand", at);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_req1_frames();
    test_both_after_reset();
    test_back_to_back();
    test_alternate();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
